// File: rtl/game_pkg.sv
// Shared definitions for the note-judging datapath: FSM encoding,
// score increments and the pixel-offset range of a slot.
package game_pkg;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_OPEN   = 2'd2;
   localparam logic [1:0] ST_CLOSED = 2'd3;

   localparam int unsigned PERF_PTS = 2;
   localparam int unsigned GOOD_PTS = 1;

   localparam logic [2:0] OFFSET_MAX = 3'd6;
endpackage

// File: rtl/btn_conditioner.sv
// Raw button to one-cycle press pulse: two-flop synchronizer, stability
// counter, then rising-edge detect on the accepted level.
module btn_conditioner #(
   parameter int DEBOUNCE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic          s1, s2, lvl, lvl_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         lvl   <= 1'b0;
         lvl_d <= 1'b0;
         cnt   <= '0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         lvl_d <= lvl;
         // cnt tracks how many consecutive samples have disagreed with lvl
         if (s2 == lvl) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE - 1)) begin
            lvl <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = lvl & ~lvl_d;
endmodule

// File: rtl/judge_ctrl.sv
// Hit-judgement controller: conditions the two player buttons, grades
// presses against the judge-column note and keeps combo/score/miss totals.
module judge_ctrl #(
   parameter int DEBOUNCE = 16,
   parameter int PERF_LO  = 2,
   parameter int PERF_HI  = 4,
   parameter int PERF_PTS = int'(game_pkg::PERF_PTS),
   parameter int GOOD_PTS = int'(game_pkg::GOOD_PTS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        clear,
   input  logic        red_btn,
   input  logic        blue_btn,
   input  logic        note_R_judge,
   input  logic        note_B_judge,
   input  logic [2:0]  offset,
   input  logic        note_step,
   output logic        delete,
   output logic        hit_perfect,
   output logic        hit_good,
   output logic        miss,
   output logic [7:0]  combo,
   output logic [7:0]  max_combo,
   output logic [15:0] score,
   output logic [7:0]  miss_cnt
);
   import game_pkg::*;

   logic        press_r, press_b;
   logic [1:0]  state, state_n;
   logic        note_any, in_open, hit, bad, step_miss, perf;
   logic [7:0]  combo_inc, miss_inc;
   logic [16:0] score_sum;
   logic [15:0] score_inc;

   btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_red (
      .clk(clk), .rst(rst), .btn(red_btn), .press(press_r)
   );

   btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_blue (
      .clk(clk), .rst(rst), .btn(blue_btn), .press(press_b)
   );

   always_comb begin
      note_any  = note_R_judge | note_B_judge;
      in_open   = enable && (state == ST_OPEN);
      hit       = in_open && !(press_r && press_b) &&
                  ((press_r && note_R_judge) || (press_b && note_B_judge));
      bad       = in_open && (press_r || press_b) && !hit;
      step_miss = in_open && note_step && !press_r && !press_b;
      perf      = (offset >= 3'(PERF_LO)) && (offset <= 3'(PERF_HI)) &&
                  (offset <= OFFSET_MAX);

      combo_inc = (combo == 8'hFF) ? combo : combo + 8'd1;
      miss_inc  = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
      score_sum = {1'b0, score} + (perf ? 17'(PERF_PTS) : 17'(GOOD_PTS));
      score_inc = score_sum[16] ? 16'hFFFF : score_sum[15:0];

      // The datapath presents the post-shift column alongside note_step.
      state_n = state;
      case (state)
         ST_IDLE:   state_n = ST_WAIT;
         ST_WAIT:   if (note_any) state_n = ST_OPEN;
         ST_OPEN: begin
            if (hit || bad || step_miss) begin
               if (note_step) state_n = note_any ? ST_OPEN : ST_WAIT;
               else           state_n = ST_CLOSED;
            end
         end
         ST_CLOSED: if (note_step) state_n = note_any ? ST_OPEN : ST_WAIT;
         default:   state_n = ST_IDLE;
      endcase
      if (!enable) state_n = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         delete      <= 1'b0;
         hit_perfect <= 1'b0;
         hit_good    <= 1'b0;
         miss        <= 1'b0;
         combo       <= '0;
         max_combo   <= '0;
         score       <= '0;
         miss_cnt    <= '0;
      end else begin
         state       <= state_n;
         delete      <= hit;
         hit_perfect <= hit && perf;
         hit_good    <= hit && !perf;
         miss        <= bad || step_miss;

         if (clear) begin
            combo     <= '0;
            max_combo <= '0;
            score     <= '0;
            miss_cnt  <= '0;
         end else if (hit) begin
            combo <= combo_inc;
            score <= score_inc;
            if (combo_inc > max_combo) max_combo <= combo_inc;
         end else if (bad || step_miss) begin
            combo    <= '0;
            miss_cnt <= miss_inc;
         end
      end
   end
endmodule

// File: doc/judge_ctrl.md
Name: judge_ctrl

Overview:
- Hit-judgement controller for the falling-note datapath.
- Conditions the red and blue player buttons and compares each press against the note in the judge column (note_R_judge / note_B_judge).
- Grades each hit by pixel offset and issues a one-cycle delete pulse to remove a hit note.
- Owns combo, max-combo, score and miss bookkeeping for the song currently playing.

Parameters:
- DEBOUNCE, 16, cycles a raw button must hold stable before its level is accepted.
- PERF_LO, 2, lowest offset graded PERFECT.
- PERF_HI, 4, highest offset graded PERFECT.
- PERF_PTS, 2, score added per PERFECT.
- GOOD_PTS, 1, score added per GOOD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  song playing; low = block idle, no judging.
- clear  in  1  one-cycle pulse at song start; zeroes combo, max_combo, score, miss_cnt.
- red_btn  in  1  raw red button, asynchronous.
- blue_btn  in  1  raw blue button, asynchronous.
- note_R_judge  in  1  red note in judge column.
- note_B_judge  in  1  blue note in judge column.
- offset  in  3  pixel offset 0..6 of the current slot.
- note_step  in  1  one-cycle pulse: judge-column contents shift this cycle.
- delete  out  1  one-cycle pulse: remove judge-column note.
- hit_perfect  out  1  one-cycle grade strobe.
- hit_good  out  1  one-cycle grade strobe.
- miss  out  1  one-cycle miss strobe.
- combo  out  8  current combo, saturates at 255.
- max_combo  out  8  highest combo this song.
- score  out  16  accumulated score, saturates at 65535.
- miss_cnt  out  8  misses this song, saturates at 255.

Behaviour:
- Reset (rst==0 at a clk edge): every output 0; FSM in IDLE; conditioner state cleared.
- Button conditioning:
  - 2-flop synchronizer, then a counter requiring DEBOUNCE equal consecutive samples, then rising-edge detect.
  - Produces press_r / press_b, each one cycle wide.
  - Raw edge to press pulse: 2+DEBOUNCE cycles.
- FSM states:
  - IDLE: enable==0. Enter WAIT when enable==1.
  - WAIT: no note present. Go to OPEN when (note_R_judge|note_B_judge)==1.
  - OPEN: note present and not yet judged.
  - CLOSED: note judged; wait for note_step.
  - enable==0 in any state goes to IDLE next cycle and drops any pending judgement without a miss.
- OPEN, press of the matching colour only (press_r with note_R_judge, or press_b with note_B_judge):
  - delete=1 in the next cycle.
  - Grade: PERFECT if PERF_LO<=offset<=PERF_HI, sampled in the press cycle; GOOD otherwise.
  - Matching strobe in the same cycle as delete.
  - combo+1 (saturating); score+PTS (saturating).
  - max_combo updates to the new combo in the same cycle if it is larger.
  - Go to CLOSED.
- OPEN, wrong colour, or press_r and press_b in the same cycle:
  - miss=1 next cycle; combo=0; miss_cnt+1; no delete.
  - Go to CLOSED.
- OPEN, note_step without a press: miss as above.
  - Next state is OPEN if a note is present after the shift, otherwise WAIT.
- OPEN, press and note_step in the same cycle: the press is judged; the step then applies from CLOSED.
- CLOSED, note_step: next state is OPEN if a note is present, else WAIT. Further presses in CLOSED are ignored.
- WAIT, any press: ignored, no penalty.
- clear has priority over every counter update in the same cycle; FSM state is unaffected.
- All outputs registered; strobes never overlap; delete is high only in a hit cycle.

Decomposition:
- Shared package game_pkg holds:
  - FSM state encoding (IDLE/WAIT/OPEN/CLOSED, 2 bits)
  - point constants PERF_PTS and GOOD_PTS
  - OFFSET_MAX=6
- Sub-module btn_conditioner (parameter DEBOUNCE) handles sync, debounce and rising edge, one instance per button.
- judge_ctrl contains the FSM, grading and counters.

Test Plan:
- Reset, then enable=1, red note present, red press at offset=3 -> delete and hit_perfect 1 cycle; combo=1, score=2, max_combo=1.
- Blue note present, blue press at offset=6 -> hit_good; score+1; a second blue press before note_step -> no response.
- Red note present, blue press -> miss=1, combo 5->0, miss_cnt+1, no delete, max_combo stays 5.
- Red note present, no press, note_step -> miss; new blue note present after step -> state OPEN; blue press at offset=2 -> hit_perfect.
- Red glitch of DEBOUNCE-1 cycles -> no press pulse; red held for DEBOUNCE+2 cycles -> exactly one press pulse.
- combo at 255 plus hit -> combo stays 255; clear pulse -> combo, max_combo, score and miss_cnt all 0; rst low during OPEN -> all outputs 0 and state IDLE.
